seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver.sv | 227 ++++++++++++++++++++++
 tb/tb_seg_display_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_driver.sv
// Four-digit seven-segment driver: registered 8-bit value -> double-dabble BCD -> multiplexed scan.
// Define SEG_DISPLAY_SIGNED_EN to display two's-complement input with a leading minus sign.
module seg_display_driver #(
    parameter int SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       oi,
    input  logic [7:0] data,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t stateReg, stateNext;

    logic [1:0]       rstSyncReg;
    logic             runEn;
    logic [7:0]       shadowReg;
    logic [11:0]      bcdReg;
    logic [11:0]      bcdAdj;
    logic [2:0]       iterReg;
    logic             convNegReg;
    logic [7:0]       pendReg;
    logic             pendValidReg;
    logic [3:0]       dispHundReg, dispTensReg, dispOnesReg;
    logic             dispNegReg;
    logic             busyReg;
    logic [PRE_W-1:0] prescalerReg;
    logic [1:0]       digitReg;
    logic [6:0]       segReg, segNext;
    logic [3:0]       anReg, anNext;

    logic             startConv;
    logic             storePend;
    logic [7:0]       startRaw;
    logic [7:0]       startMag;
    logic             startNeg;

    // Assertion is immediate; release reaches the logic only after two clean edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstSyncReg <= 2'b00;
        end else begin
            rstSyncReg <= {rstSyncReg[0], 1'b1};
        end
    end

    assign runEn = rstSyncReg[1];

    function automatic logic [6:0] segCode(input logic [3:0] digit);
        case (digit)
            4'd0:    segCode = 7'h40;
            4'd1:    segCode = 7'h79;
            4'd2:    segCode = 7'h24;
            4'd3:    segCode = 7'h30;
            4'd4:    segCode = 7'h19;
            4'd5:    segCode = 7'h12;
            4'd6:    segCode = 7'h02;
            4'd7:    segCode = 7'h78;
            4'd8:    segCode = 7'h00;
            4'd9:    segCode = 7'h10;
            default: segCode = SEG_BLANK;
        endcase
    endfunction

    // A strobe landing on the commit cycle is newer than anything pending, so it wins.
    assign startRaw = oi ? data : pendReg;

`ifdef SEG_DISPLAY_SIGNED_EN
    assign startNeg = startRaw[7];
    assign startMag = startRaw[7] ? (~startRaw + 8'd1) : startRaw;
`else
    assign startNeg = 1'b0;
    assign startMag = startRaw;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
        end else if (runEn) begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        startConv = 1'b0;
        storePend = 1'b0;
        case (stateReg)
            IDLE: begin
                if (oi) begin
                    startConv = 1'b1;
                    stateNext = CONV;
                end
            end
            CONV: begin
                storePend = oi;
                if (iterReg == 3'd7) begin
                    stateNext = COMMIT;
                end
            end
            COMMIT: begin
                if (oi || pendValidReg) begin
                    startConv = 1'b1;
                    stateNext = CONV;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble ahead of each shift.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_dabble
            assign bcdAdj[gi*4 +: 4] = (bcdReg[gi*4 +: 4] >= 4'd5) ?
                                       (bcdReg[gi*4 +: 4] + 4'd3) : bcdReg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadowReg    <= 8'd0;
            bcdReg       <= 12'd0;
            iterReg      <= 3'd0;
            convNegReg   <= 1'b0;
            pendReg      <= 8'd0;
            pendValidReg <= 1'b0;
            dispHundReg  <= 4'd0;
            dispTensReg  <= 4'd0;
            dispOnesReg  <= 4'd0;
            dispNegReg   <= 1'b0;
            busyReg      <= 1'b0;
        end else if (runEn) begin
            if (startConv) begin
                shadowReg  <= startMag;
                convNegReg <= startNeg;
                bcdReg     <= 12'd0;
                iterReg    <= 3'd0;
            end else if (stateReg == CONV) begin
                {bcdReg, shadowReg} <= {bcdAdj, shadowReg} << 1;
                iterReg             <= iterReg + 3'd1;
            end

            if (stateReg == COMMIT) begin
                dispHundReg <= bcdReg[11:8];
                dispTensReg <= bcdReg[7:4];
                dispOnesReg <= bcdReg[3:0];
                dispNegReg  <= convNegReg;
            end

            if (storePend) begin
                pendReg      <= data;
                pendValidReg <= 1'b1;
            end else if (stateReg == COMMIT) begin
                pendValidReg <= 1'b0;
            end

            busyReg <= (stateNext != IDLE);
        end
    end

    always_comb begin
        segNext = SEG_BLANK;
        case (digitReg)
            2'd0: segNext = segCode(dispOnesReg);
            2'd1: begin
                if ((dispHundReg != 4'd0) || (dispTensReg != 4'd0)) begin
                    segNext = segCode(dispTensReg);
                end
            end
            2'd2: begin
                if (dispHundReg != 4'd0) begin
                    segNext = segCode(dispHundReg);
                end
            end
            default: begin
                if (dispNegReg) begin
                    segNext = SEG_MINUS;
                end
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_an
            assign anNext[gi] = (digitReg != 2'(gi));
        end
    endgenerate

    // Outputs for the current digit are latched on the wrap edge, then the index moves on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescalerReg <= '0;
            digitReg     <= 2'd0;
            segReg       <= SEG_BLANK;
            anReg        <= 4'hF;
        end else if (runEn) begin
            if (prescalerReg == PRE_MAX) begin
                prescalerReg <= '0;
                digitReg     <= digitReg + 2'd1;
                segReg       <= segNext;
                anReg        <= anNext;
            end else begin
                prescalerReg <= prescalerReg + 1'b1;
            end
        end
    end

    assign seg  = segReg;
    assign an   = anReg;
    assign busy = busyReg;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: directed cases plus random strobes against a
// cycle-level behavioural model of conversion timing and the decimal scan display.
module tb_seg_display_driver;

    localparam int SD = 4;

    logic       clk;
    logic       rst;
    logic       oi;
    logic [7:0] data;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int total = 0;
    int bad   = 0;

    seg_display_driver #(.SCAN_DIV(SD)) dut (
        .clk  (clk),
        .rst  (rst),
        .oi   (oi),
        .data (data),
        .seg  (seg),
        .an   (an),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [6:0] segTbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int         edgeNo = 0;
    bit         conv = 0;
    int         convStart = 0;
    logic [7:0] convRaw = 8'd0;
    bit         pendValid = 0;
    logic [7:0] pendRaw = 8'd0;
    int         dispVal = 0;
    bit         dispNeg = 0;
    bit         scanSynced = 0;
    int         scanCnt = 0;
    int         dig = 0;
    logic [6:0] expSeg = 7'h7F;
    logic [3:0] expAn = 4'hF;
    bit         expBusy = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h edge=%0d", tag, got, want, edgeNo);
        end
    endtask

    function automatic logic [6:0] digitSeg(input int d);
        logic [6:0] r;
        r = 7'h7F;
        case (d)
            0: r = segTbl[dispVal % 10];
            1: if (dispVal >= 10) r = segTbl[(dispVal / 10) % 10];
            2: if (dispVal >= 100) r = segTbl[dispVal / 100];
            default: if (dispNeg) r = 7'h3F;
        endcase
        return r;
    endfunction

    task automatic setDisp(input logic [7:0] raw);
`ifdef SEG_DISPLAY_SIGNED_EN
        dispNeg = (raw >= 8'd128);
        dispVal = dispNeg ? (256 - int'(raw)) : int'(raw);
`else
        dispNeg = 0;
        dispVal = int'(raw);
`endif
    endtask

    task automatic startModel(input logic [7:0] raw);
        conv      = 1;
        convStart = edgeNo;
        convRaw   = raw;
    endtask

    // Advance the model by one rising edge, given the strobe the DUT sampled at it.
    task automatic modelEdge(input logic o, input logic [7:0] d);
        if (scanSynced) begin
            if (scanCnt == SD - 1) begin
                expAn   = ~(4'b0001 << dig);
                expSeg  = digitSeg(dig);
                dig     = (dig + 1) % 4;
                scanCnt = 0;
            end else begin
                scanCnt++;
            end
        end
        if (conv && edgeNo == convStart + 9) begin
            setDisp(convRaw);
            if (o) startModel(d);
            else if (pendValid) startModel(pendRaw);
            else conv = 0;
            pendValid = 0;
        end else if (conv) begin
            if (o) begin
                pendRaw   = d;
                pendValid = 1;
            end
        end else if (o) begin
            startModel(d);
        end
        expBusy = conv;
    endtask

    task automatic tick(input logic o, input logic [7:0] d, input bit scanChk);
        @(negedge clk);
        oi   = o;
        data = d;
        @(posedge clk);
        edgeNo++;
        modelEdge(o, d);
        #1;
        if (o) $display("txn edge=%0d data=%0d busy_before=%0b", edgeNo, d, busy);
        checkVal("busy", busy, expBusy);
        if (scanChk) begin
            checkVal("an", an, expAn);
            checkVal("seg", seg, expSeg);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 1'b1);
    endtask

    // Lock the scan model onto the first digit-0 refresh after reset release.
    task automatic syncScan();
        bit found;
        found = 0;
        scanSynced = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1'b0, 8'd0, 1'b0);
            if (an != 4'hF) found = 1;
        end
        checkVal("scan_start", found, 1);
        checkVal("first_an", an, 4'b1110);
        checkVal("first_seg", seg, 7'h40);
        expAn      = 4'b1110;
        expSeg     = digitSeg(0);
        dig        = 1;
        scanCnt    = 0;
        scanSynced = 1;
    endtask

    task automatic resetModel();
        conv       = 0;
        pendValid  = 0;
        dispVal    = 0;
        dispNeg    = 0;
        scanSynced = 0;
        expSeg     = 7'h7F;
        expAn      = 4'hF;
        expBusy    = 0;
    endtask

    initial begin
        rst  = 1'b0;
        oi   = 1'b0;
        data = 8'd0;
        repeat (3) @(negedge clk);
        checkVal("rst_seg", seg, 7'h7F);
        checkVal("rst_an", an, 4'hF);
        checkVal("rst_busy", busy, 1'b0);
        rst = 1'b1;
        syncScan();

        // Idle scan: 1110,1101,1011,0111 with only the ones digit lit
        idle(16);

        // Max unsigned / -1 signed, small value, three-digit value, -128
        tick(1'b1, 8'hFF, 1'b1); idle(24);
        tick(1'b1, 8'd7,  1'b1); idle(24);
        tick(1'b1, 8'd100, 1'b1); idle(24);
        tick(1'b1, 8'h80, 1'b1); idle(24);

        // Pending overwrite: 9 is superseded by 200
        tick(1'b1, 8'd42, 1'b1);
        idle(2);
        tick(1'b1, 8'd9, 1'b1);
        idle(1);
        tick(1'b1, 8'd200, 1'b1);
        idle(30);

        // Strobe landing exactly on the commit cycle
        tick(1'b1, 8'd123, 1'b1);
        idle(8);
        tick(1'b1, 8'd45, 1'b1);
        idle(30);

        // Reset in the middle of converting 55 with a pending value queued
        tick(1'b1, 8'd55, 1'b1);
        tick(1'b1, 8'd77, 1'b1);
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("midrst_seg", seg, 7'h7F);
        checkVal("midrst_an", an, 4'hF);
        checkVal("midrst_busy", busy, 1'b0);
        resetModel();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        syncScan();
        idle(20);

        // Random strobes
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 6) == 0), 8'($urandom), 1'b1);
        end
        idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
